dram_port_arbiter: RTL and testbench
====================================

Name: dram_port_arbiter

Overview:
- Shares the single 128-bit data-memory port between two requesters:
  - the CPU data-cache refill/writeback path;
  - the UART monitor's dump, write and trash sequencer.
- Latches the monitor's single-cycle request pulses, arbitrates round-robin and keeps at most one memory transaction outstanding.
- Steers the read data and write response back to the winning requester.
- A response watchdog guarantees the port never deadlocks.

Parameters:
- TMO_CYCLES, 1023: cycles to wait for mem_rd_valid/mem_wr_resp before aborting. Must be ≥ 2.
- TCW, 10: width of the watchdog counter. Requires 2^TCW > TMO_CYCLES.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- mon_rd_req  in  1  monitor read request pulse
- mon_rd_adr  in  32  monitor read address; [3:0] ignored
- mon_wr_req  in  1  monitor write request pulse
- mon_wr_adr  in  32  monitor write address; [3:0] ignored
- mon_wdata  in  128  monitor write data
- mon_mask  in  16  monitor byte mask; 1 = byte NOT written
- mon_rd_valid  out  1  one-cycle pulse: mem_rd_data belongs to monitor
- mon_finish_wresp  out  1  one-cycle pulse: monitor write done
- mon_busy  out  1  monitor request latched or in flight
- cpu_rd_req  in  1  CPU read request, level, held until ack
- cpu_wr_req  in  1  CPU write request, level, held until ack
- cpu_adr  in  32  CPU address
- cpu_wdata  in  128  CPU write data
- cpu_mask  in  16  CPU byte mask
- cpu_rd_ack  out  1  one-cycle pulse: read data valid for CPU
- cpu_wr_ack  out  1  one-cycle pulse: CPU write done
- mem_rd_req  out  1  one-cycle read command
- mem_wr_req  out  1  one-cycle write command
- mem_adr  out  32  command address, [3:0] forced to 0
- mem_wdata  out  128  command write data
- mem_mask  out  16  command byte mask
- mem_rd_valid  in  1  read data return strobe
- mem_wr_resp  in  1  write response strobe
- mem_rd_data  in  128  read data
- rd_data  out  128  mem_rd_data passed through combinationally to both requesters
- tmo_err  out  1  sticky watchdog flag; cleared only by reset

Behaviour:
- Reset: all outputs 0 and state S_IDLE. Pending flags, last-grant bit (LG=CPU) and the watchdog are cleared. An in-flight transaction is abandoned; any later stray mem strobe while in S_IDLE is ignored.
- Monitor capture: mon_rd_req/mon_wr_req load the pending flag (mp_rd/mp_wr), address, data and mask into holding registers.
  - The pulse is ignored while mon_busy=1.
  - If rd and wr pulse together, the read is taken.
- mon_busy = mp_rd | mp_wr | (state≠S_IDLE & owner=MON).
- Arbitration, evaluated only in S_IDLE:
  - Candidates are M = mp_rd|mp_wr and C = cpu_rd_req|cpu_wr_req. If both CPU levels are high, the read wins.
  - Only M → MON. Only C → CPU.
  - Both → opposite of LG (round-robin). LG updates on grant.
  - A monitor pulse arriving in the same cycle is not a candidate until the next cycle.
- Grant cycle (S_IDLE → S_RD or S_WR):
  - mem_rd_req or mem_wr_req = 1 for exactly that cycle.
  - mem_adr/mem_wdata/mem_mask come from the winner. mem_adr[3:0] = 0.
  - The command is registered, so it appears the cycle after arbitration. Grant-to-command latency is 1 cycle.
  - mem_wdata/mem_mask hold their last value otherwise.
- S_RD: on mem_rd_valid, pulse mon_rd_valid or cpu_rd_ack (registered, 1 cycle after the strobe) and go to S_IDLE.
  - The owner's pending flag is cleared on the same edge. For the CPU, the requester drops its level after the ack.
- S_WR: on mem_wr_resp, pulse mon_finish_wresp or cpu_wr_ack likewise, then S_IDLE.
- Wrong-type strobe (mem_wr_resp in S_RD, or mem_rd_valid in S_WR): ignored.
- Back-to-back: S_IDLE lasts ≥ 1 cycle between transactions, so at most one command per 3 cycles.
- Watchdog:
  - Counter cleared on entry to S_RD/S_WR and incremented each cycle there.
  - On reaching TMO_CYCLES without a response: return to S_IDLE, pulse the owner's ack/valid/finish anyway (data undefined), set tmo_err and clear the owner's pending flag.
  - A response in the same cycle as the timeout takes precedence and tmo_err is not set.
- CPU deasserting its request before the grant: allowed, no command issued. Deasserting after the grant: the transaction still completes and the ack pulses.

Test Plan:
- Monitor only:
  - Stimulus: mon_rd_req pulse, adr 0x0000_1238; mem_rd_valid 4 cycles after the command with data 0x…DEADBEEF.
  - Required: mem_rd_req at cycle+1 with mem_adr 0x0000_1230. mon_rd_valid 1 cycle after the strobe with rd_data equal to mem_rd_data. mon_busy low afterwards. cpu_rd_ack stays 0.
- Contention:
  - Stimulus: cpu_wr_req held and mon_wr_req pulsed in the same cycle, from reset.
  - Required: MON is granted first (LG=CPU), then CPU. Exactly one mem_wr_req per transaction, each carrying its requester's mask. LG alternates over 4 further contended rounds.
- Overflow:
  - Stimulus: second mon_rd_req while mon_busy=1.
  - Required: it is ignored. Exactly one mem_rd_req, and the held address is unchanged.
- Timeout:
  - Stimulus: CPU read with no mem_rd_valid; TMO_CYCLES=8 in the bench.
  - Required: cpu_rd_ack 8 cycles after entering S_RD, tmo_err=1, state S_IDLE. A later stray mem_rd_valid produces no ack.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 while in S_WR with a monitor read pending.
  - Required: all outputs 0 immediately (asynchronous). After release, no command is issued until a new request arrives.
- Simultaneous response/timeout:
  - Stimulus: mem_wr_resp arrives exactly on the timeout cycle.
  - Required: normal ack and tmo_err stays 0.

Source files
------------

// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter: round-robin sharing of the 128-bit memory port between CPU and UART monitor
module dram_port_arbiter #(
  parameter int TMO_CYCLES = 1023,
  parameter int TCW = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mon_rd_req,
  input  logic [31:0]  mon_rd_adr,
  input  logic         mon_wr_req,
  input  logic [31:0]  mon_wr_adr,
  input  logic [127:0] mon_wdata,
  input  logic [15:0]  mon_mask,
  output logic         mon_rd_valid,
  output logic         mon_finish_wresp,
  output logic         mon_busy,
  input  logic         cpu_rd_req,
  input  logic         cpu_wr_req,
  input  logic [31:0]  cpu_adr,
  input  logic [127:0] cpu_wdata,
  input  logic [15:0]  cpu_mask,
  output logic         cpu_rd_ack,
  output logic         cpu_wr_ack,
  output logic         mem_rd_req,
  output logic         mem_wr_req,
  output logic [31:0]  mem_adr,
  output logic [127:0] mem_wdata,
  output logic [15:0]  mem_mask,
  input  logic         mem_rd_valid,
  input  logic         mem_wr_resp,
  input  logic [127:0] mem_rd_data,
  output logic [127:0] rd_data,
  output logic         tmo_err
);
  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;
  localparam logic [TCW-1:0] TMO_LAST = TCW'(TMO_CYCLES - 1);
  state_t state_q, state_d;
  logic owner_q, owner_d;
  logic lg_q, lg_d;
  logic mp_rd_q, mp_rd_d, mp_wr_q, mp_wr_d;
  logic [31:0] ma_q, ma_d;
  logic [127:0] mw_q, mw_d;
  logic [15:0] mm_q, mm_d;
  logic [TCW-1:0] cnt_q, cnt_d;
  logic mem_rd_req_q, mem_rd_req_d, mem_wr_req_q, mem_wr_req_d;
  logic [31:0] mem_adr_q, mem_adr_d;
  logic [127:0] mem_wdata_q, mem_wdata_d;
  logic [15:0] mem_mask_q, mem_mask_d;
  logic mon_rd_valid_q, mon_rd_valid_d, mon_finish_wresp_q, mon_finish_wresp_d;
  logic cpu_rd_ack_q, cpu_rd_ack_d, cpu_wr_ack_q, cpu_wr_ack_d;
  logic tmo_err_q, tmo_err_d;
  logic m_cand, c_cand, g_mon, g_cpu, rd_op, resp, tmo;
  assign mon_busy = mp_rd_q | mp_wr_q | ((state_q != S_IDLE) & owner_q);
  assign rd_data = mem_rd_data;
  assign mem_rd_req = mem_rd_req_q;
  assign mem_wr_req = mem_wr_req_q;
  assign mem_adr = mem_adr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_mask = mem_mask_q;
  assign mon_rd_valid = mon_rd_valid_q;
  assign mon_finish_wresp = mon_finish_wresp_q;
  assign cpu_rd_ack = cpu_rd_ack_q;
  assign cpu_wr_ack = cpu_wr_ack_q;
  assign tmo_err = tmo_err_q;
  // Capture monitor pulses, arbitrate in idle, issue one command, and retire it on response or watchdog
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    lg_d = lg_q;
    mp_rd_d = mp_rd_q;
    mp_wr_d = mp_wr_q;
    ma_d = ma_q;
    mw_d = mw_q;
    mm_d = mm_q;
    cnt_d = (state_q == S_IDLE) ? '0 : cnt_q + 1'b1;
    mem_rd_req_d = 1'b0;
    mem_wr_req_d = 1'b0;
    mem_adr_d = mem_adr_q;
    mem_wdata_d = mem_wdata_q;
    mem_mask_d = mem_mask_q;
    mon_rd_valid_d = 1'b0;
    mon_finish_wresp_d = 1'b0;
    cpu_rd_ack_d = 1'b0;
    cpu_wr_ack_d = 1'b0;
    tmo_err_d = tmo_err_q;
    m_cand = mp_rd_q | mp_wr_q;
    // the CPU still holds its level during the ack cycle; keep it from being re-granted then
    c_cand = (cpu_rd_req | cpu_wr_req) & ~(cpu_rd_ack_q | cpu_wr_ack_q);
    g_mon = (state_q == S_IDLE) && m_cand && (!c_cand || !lg_q);
    g_cpu = (state_q == S_IDLE) && c_cand && !g_mon;
    rd_op = g_mon ? mp_rd_q : cpu_rd_req;
    resp = ((state_q == S_RD) && mem_rd_valid) || ((state_q == S_WR) && mem_wr_resp);
    tmo = (state_q != S_IDLE) && (cnt_q == TMO_LAST);
    if (!mon_busy && (mon_rd_req || mon_wr_req)) begin
      mp_rd_d = mon_rd_req;
      mp_wr_d = !mon_rd_req;
      ma_d = mon_rd_req ? mon_rd_adr : mon_wr_adr;
      mw_d = mon_wdata;
      mm_d = mon_mask;
    end
    if (g_mon || g_cpu) begin
      state_d = rd_op ? S_RD : S_WR;
      owner_d = g_mon;
      lg_d = g_mon;
      mem_rd_req_d = rd_op;
      mem_wr_req_d = !rd_op;
      mem_adr_d = (g_mon ? ma_q : cpu_adr) & 32'hFFFF_FFF0;
      mem_wdata_d = g_mon ? mw_q : cpu_wdata;
      mem_mask_d = g_mon ? mm_q : cpu_mask;
    end
    if (resp || tmo) begin
      state_d = S_IDLE;
      mon_rd_valid_d = owner_q && (state_q == S_RD);
      mon_finish_wresp_d = owner_q && (state_q == S_WR);
      cpu_rd_ack_d = !owner_q && (state_q == S_RD);
      cpu_wr_ack_d = !owner_q && (state_q == S_WR);
      mp_rd_d = owner_q ? 1'b0 : mp_rd_d;
      mp_wr_d = owner_q ? 1'b0 : mp_wr_d;
      tmo_err_d = tmo_err_q | !resp;
    end
  end
  // State and output registers; reset abandons any in-flight transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      lg_q <= 1'b0;
      mp_rd_q <= 1'b0;
      mp_wr_q <= 1'b0;
      ma_q <= '0;
      mw_q <= '0;
      mm_q <= '0;
      cnt_q <= '0;
      mem_rd_req_q <= 1'b0;
      mem_wr_req_q <= 1'b0;
      mem_adr_q <= '0;
      mem_wdata_q <= '0;
      mem_mask_q <= '0;
      mon_rd_valid_q <= 1'b0;
      mon_finish_wresp_q <= 1'b0;
      cpu_rd_ack_q <= 1'b0;
      cpu_wr_ack_q <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      lg_q <= lg_d;
      mp_rd_q <= mp_rd_d;
      mp_wr_q <= mp_wr_d;
      ma_q <= ma_d;
      mw_q <= mw_d;
      mm_q <= mm_d;
      cnt_q <= cnt_d;
      mem_rd_req_q <= mem_rd_req_d;
      mem_wr_req_q <= mem_wr_req_d;
      mem_adr_q <= mem_adr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_mask_q <= mem_mask_d;
      mon_rd_valid_q <= mon_rd_valid_d;
      mon_finish_wresp_q <= mon_finish_wresp_d;
      cpu_rd_ack_q <= cpu_rd_ack_d;
      cpu_wr_ack_q <= cpu_wr_ack_d;
      tmo_err_q <= tmo_err_d;
    end
  end
endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb_dram_port_arbiter: directed scenario bench for the memory port arbiter
module tb_dram_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mon_rd_req = 0, mon_wr_req = 0;
  logic [31:0] mon_rd_adr = 0, mon_wr_adr = 0;
  logic [127:0] mon_wdata = 0;
  logic [15:0] mon_mask = 0;
  logic mon_rd_valid, mon_finish_wresp, mon_busy;
  logic cpu_rd_req = 0, cpu_wr_req = 0;
  logic [31:0] cpu_adr = 0;
  logic [127:0] cpu_wdata = 0;
  logic [15:0] cpu_mask = 0;
  logic cpu_rd_ack, cpu_wr_ack;
  logic mem_rd_req, mem_wr_req;
  logic [31:0] mem_adr;
  logic [127:0] mem_wdata;
  logic [15:0] mem_mask;
  logic mem_rd_valid = 0, mem_wr_resp = 0;
  logic [127:0] mem_rd_data = 0;
  logic [127:0] rd_data;
  logic tmo_err;
  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [127:0] RD_PAT = 128'h0123_4567_89AB_CDEF_0000_0000_DEAD_BEEF;

  dram_port_arbiter #(.TMO_CYCLES(8), .TCW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .mon_rd_req(mon_rd_req), .mon_rd_adr(mon_rd_adr), .mon_wr_req(mon_wr_req), .mon_wr_adr(mon_wr_adr),
    .mon_wdata(mon_wdata), .mon_mask(mon_mask), .mon_rd_valid(mon_rd_valid),
    .mon_finish_wresp(mon_finish_wresp), .mon_busy(mon_busy),
    .cpu_rd_req(cpu_rd_req), .cpu_wr_req(cpu_wr_req), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
    .cpu_mask(cpu_mask), .cpu_rd_ack(cpu_rd_ack), .cpu_wr_ack(cpu_wr_ack),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_mask(mem_mask), .mem_rd_valid(mem_rd_valid), .mem_wr_resp(mem_wr_resp),
    .mem_rd_data(mem_rd_data), .rd_data(rd_data), .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    n_cmp++;
    if ({mem_rd_req, mem_wr_req, mon_rd_valid, mon_finish_wresp, cpu_rd_ack, cpu_wr_ack, mon_busy, tmo_err} !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 00000000",
               {mem_rd_req, mem_wr_req, mon_rd_valid, mon_finish_wresp, cpu_rd_ack, cpu_wr_ack, mon_busy, tmo_err});
    end
    n_cmp++;
    if ({mem_adr, mem_mask, mem_wdata} !== 176'h0) begin
      n_bad++;
      $display("FAIL reset_cmd: got adr %h mask %h wdata %h want zeros", mem_adr, mem_mask, mem_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mon_read;
    mon_rd_adr = 32'h0000_1238;
    mon_rd_req = 1'b1;
    @(negedge clk);
    mon_rd_req = 1'b0;
    n_cmp++;
    if ({mem_rd_req, mon_busy} !== 2'b01) begin
      n_bad++;
      $display("FAIL mon_capture: got rd_req,busy=%b want 01", {mem_rd_req, mon_busy});
    end
    @(negedge clk);
    n_cmp++;
    if ({mem_rd_req, mem_wr_req, mem_adr} !== {2'b10, 32'h0000_1230}) begin
      n_bad++;
      $display("FAIL mon_cmd: got rd %b wr %b adr %h want 1 0 00001230", mem_rd_req, mem_wr_req, mem_adr);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({mem_rd_req, mon_rd_valid} !== 2'b00) begin
      n_bad++;
      $display("FAIL mon_wait: got rd_req,valid=%b want 00", {mem_rd_req, mon_rd_valid});
    end
    @(negedge clk);
    mem_rd_data = RD_PAT;
    mem_rd_valid = 1'b1;
    @(negedge clk);
    mem_rd_valid = 1'b0;
    n_cmp++;
    if ({mon_rd_valid, cpu_rd_ack, mon_busy} !== 3'b100) begin
      n_bad++;
      $display("FAIL mon_valid: got valid,cpu_ack,busy=%b want 100", {mon_rd_valid, cpu_rd_ack, mon_busy});
    end
    n_cmp++;
    if (rd_data !== RD_PAT) begin
      n_bad++;
      $display("FAIL mon_rd_data: got %h want %h", rd_data, RD_PAT);
    end
    @(negedge clk);
    n_cmp++;
    if ({mon_rd_valid, cpu_rd_ack, mon_busy} !== 3'b000) begin
      n_bad++;
      $display("FAIL mon_after: got valid,cpu_ack,busy=%b want 000", {mon_rd_valid, cpu_rd_ack, mon_busy});
    end
  endtask

  task automatic test_overflow;
    int ncmd = 0;
    int nval = 0;
    mon_rd_adr = 32'h0000_5670;
    mon_rd_req = 1'b1;
    @(negedge clk);
    mon_rd_adr = 32'h0000_9990;
    n_cmp++;
    if (mon_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_busy: got %b want 1", mon_busy);
    end
    @(negedge clk);
    n_cmp++;
    if ({mem_rd_req, mem_adr} !== {1'b1, 32'h0000_5670}) begin
      n_bad++;
      $display("FAIL ovf_cmd: got rd %b adr %h want 1 00005670", mem_rd_req, mem_adr);
    end
    @(negedge clk);
    mon_rd_req = 1'b0;
    mem_rd_valid = 1'b1;
    @(negedge clk);
    mem_rd_valid = 1'b0;
    n_cmp++;
    if (mon_rd_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_valid: got %b want 1", mon_rd_valid);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ncmd += int'(mem_rd_req) + int'(mem_wr_req);
      nval += int'(mon_rd_valid);
    end
    n_cmp++;
    if (ncmd != 0 || nval != 0 || mon_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_ignored: got extra cmds %0d valids %0d busy %b want 0 0 0", ncmd, nval, mon_busy);
    end
  endtask

  task automatic test_resp_at_timeout;
    cpu_adr = 32'hABCD_EF07;
    cpu_wdata = 128'hCAFE_0000_1111_2222_3333_4444_5555_6666;
    cpu_mask = 16'h00F0;
    cpu_wr_req = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({mem_wr_req, mem_adr, mem_mask, mem_wdata} !== {1'b1, 32'hABCD_EF00, 16'h00F0, cpu_wdata}) begin
      n_bad++;
      $display("FAIL sim_cmd: got wr %b adr %h mask %h wdata %h", mem_wr_req, mem_adr, mem_mask, mem_wdata);
    end
    repeat (7) @(negedge clk);
    n_cmp++;
    if ({cpu_wr_ack, tmo_err} !== 2'b00) begin
      n_bad++;
      $display("FAIL sim_early: got ack,tmo=%b want 00", {cpu_wr_ack, tmo_err});
    end
    mem_wr_resp = 1'b1;
    @(negedge clk);
    mem_wr_resp = 1'b0;
    cpu_wr_req = 1'b0;
    n_cmp++;
    if ({cpu_wr_ack, tmo_err} !== 2'b10) begin
      n_bad++;
      $display("FAIL sim_ack: got ack,tmo=%b want 10", {cpu_wr_ack, tmo_err});
    end
    @(negedge clk);
    n_cmp++;
    if ({cpu_wr_ack, mem_wr_req, tmo_err} !== 3'b000) begin
      n_bad++;
      $display("FAIL sim_after: got ack,wr,tmo=%b want 000", {cpu_wr_ack, mem_wr_req, tmo_err});
    end
  endtask

  task automatic test_contention;
    int ncmd = 0;
    int mon_left = 3;
    int mon_acks = 0;
    int cpu_acks = 0;
    int cd = 0;
    logic exp_mon = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mon_wr_adr = 32'h1000_0013;
    mon_wdata = 128'h5;
    mon_mask = 16'hA5A5;
    cpu_adr = 32'h2000_0020;
    cpu_mask = 16'h5A5A;
    mon_wr_req = 1'b1;
    mon_left--;
    for (int cyc = 0; cyc < 200 && (mon_acks < 3 || cpu_acks < 3); cyc++) begin
      @(negedge clk);
      mon_wr_req = 1'b0;
      if (mem_wr_req || mem_rd_req) begin
        ncmd++;
        n_cmp++;
        if ({mem_rd_req, mem_mask} !== {1'b0, (exp_mon ? 16'hA5A5 : 16'h5A5A)}) begin
          n_bad++;
          $display("FAIL cont_grant%0d: got rd %b mask %h want 0 %h", ncmd, mem_rd_req, mem_mask,
                   exp_mon ? 16'hA5A5 : 16'h5A5A);
        end
        exp_mon = !exp_mon;
        cd = 2;
      end
      mem_wr_resp = (cd == 1);
      if (cd > 0) cd--;
      if (mon_finish_wresp) mon_acks++;
      if (cpu_wr_ack) begin
        cpu_acks++;
        cpu_wr_req = 1'b0;
      end else if (cpu_acks < 3 && !cpu_wr_req) cpu_wr_req = 1'b1;
      if (mon_left > 0 && !mon_busy) begin
        mon_wr_req = 1'b1;
        mon_left--;
      end
    end
    mem_wr_resp = 1'b0;
    cpu_wr_req = 1'b0;
    n_cmp++;
    if (ncmd != 6 || mon_acks != 3 || cpu_acks != 3) begin
      n_bad++;
      $display("FAIL cont_counts: got cmds %0d mon_acks %0d cpu_acks %0d want 6 3 3", ncmd, mon_acks, cpu_acks);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({mem_wr_req, mem_rd_req, mon_busy} !== 3'b000) begin
      n_bad++;
      $display("FAIL cont_idle: got wr,rd,busy=%b want 000", {mem_wr_req, mem_rd_req, mon_busy});
    end
  endtask

  task automatic test_timeout;
    int k = 0;
    logic seen = 1'b0;
    cpu_adr = 32'h3000_0044;
    cpu_rd_req = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({mem_rd_req, mem_adr} !== {1'b1, 32'h3000_0040}) begin
      n_bad++;
      $display("FAIL tmo_cmd: got rd %b adr %h want 1 30000040", mem_rd_req, mem_adr);
    end
    for (k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (cpu_rd_ack) break;
    end
    cpu_rd_req = 1'b0;
    n_cmp++;
    if (k != 8) begin
      n_bad++;
      $display("FAIL tmo_latency: got %0d want 8", k);
    end
    n_cmp++;
    if ({tmo_err, mem_rd_req} !== 2'b10) begin
      n_bad++;
      $display("FAIL tmo_flag: got tmo,rd=%b want 10", {tmo_err, mem_rd_req});
    end
    @(negedge clk);
    mem_rd_valid = 1'b1;
    @(negedge clk);
    mem_rd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      seen = seen | cpu_rd_ack | mon_rd_valid | mem_rd_req | mem_wr_req;
      @(negedge clk);
    end
    n_cmp++;
    if ({seen, tmo_err} !== 2'b01) begin
      n_bad++;
      $display("FAIL tmo_stray: got activity,tmo=%b want 01", {seen, tmo_err});
    end
  endtask

  task automatic test_reset_mid;
    logic seen = 1'b0;
    cpu_adr = 32'h4000_0000;
    cpu_wdata = 128'hFFFF;
    cpu_mask = 16'h8001;
    cpu_wr_req = 1'b1;
    @(negedge clk);
    mon_rd_adr = 32'h5000_0000;
    mon_rd_req = 1'b1;
    n_cmp++;
    if (mem_wr_req !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_pre_cmd: got %b want 1", mem_wr_req);
    end
    @(negedge clk);
    mon_rd_req = 1'b0;
    n_cmp++;
    if ({mon_busy, tmo_err} !== 2'b11) begin
      n_bad++;
      $display("FAIL rst_pre_busy: got busy,tmo=%b want 11", {mon_busy, tmo_err});
    end
    #2;
    rst_n = 1'b0;
    cpu_wr_req = 1'b0;
    #1;
    n_cmp++;
    if ({mem_rd_req, mem_wr_req, mon_rd_valid, mon_finish_wresp, cpu_rd_ack, cpu_wr_ack, mon_busy, tmo_err} !== 8'h00
        || {mem_adr, mem_mask, mem_wdata} !== 176'h0) begin
      n_bad++;
      $display("FAIL rst_async: got flags %b adr %h mask %h wdata %h want zeros",
               {mem_rd_req, mem_wr_req, mon_rd_valid, mon_finish_wresp, cpu_rd_ack, cpu_wr_ack, mon_busy, tmo_err},
               mem_adr, mem_mask, mem_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mem_wr_resp = 1'b1;
    @(negedge clk);
    mem_wr_resp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      seen = seen | mem_rd_req | mem_wr_req | cpu_wr_ack | mon_finish_wresp | mon_busy;
      @(negedge clk);
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_quiet: got activity %b want 0", seen);
    end
    mon_wr_adr = 32'h6000_0008;
    mon_mask = 16'h0001;
    mon_wr_req = 1'b1;
    @(negedge clk);
    mon_wr_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({mem_wr_req, mem_adr, mem_mask} !== {1'b1, 32'h6000_0000, 16'h0001}) begin
      n_bad++;
      $display("FAIL rst_resume: got wr %b adr %h mask %h want 1 60000000 0001", mem_wr_req, mem_adr, mem_mask);
    end
    mem_wr_resp = 1'b1;
    @(negedge clk);
    mem_wr_resp = 1'b0;
    n_cmp++;
    if ({mon_finish_wresp, cpu_wr_ack, tmo_err} !== 3'b100) begin
      n_bad++;
      $display("FAIL rst_finish: got fin,cpu_ack,tmo=%b want 100", {mon_finish_wresp, cpu_wr_ack, tmo_err});
    end
  endtask

  initial begin
    test_reset;
    test_mon_read;
    test_overflow;
    test_resp_at_timeout;
    test_contention;
    test_timeout;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion want finish");
    $fatal(1, "bench time limit");
  end
endmodule
